// File: rtl/serial_adder_ctrl_if.sv
// Handshake/operand bundle for serial_adder_ctrl.
// Optional ovf signal present when SERIAL_ADD_OVF_EN is defined.
interface serial_adder_ctrl_if #(
  parameter int unsigned WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
`ifdef SERIAL_ADD_OVF_EN
  logic             ovf;

  modport master (output start, a_in, b_in, cin, input busy, done, sum, cout, ovf);
  modport slave  (input start, a_in, b_in, cin, output busy, done, sum, cout, ovf);
`else
  modport master (output start, a_in, b_in, cin, input busy, done, sum, cout);
  modport slave  (input start, a_in, b_in, cin, output busy, done, sum, cout);
`endif
endinterface

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder controller: one full-adder cell reused across WIDTH cycles, LSB first.
// Define SERIAL_ADD_OVF_EN to add the two's-complement overflow output (bus.ovf).
module serial_adder_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  serial_adder_ctrl_if.slave bus
);
  localparam int unsigned CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sr, b_sr, sum_q;
  logic [CW-1:0]    cnt;
  logic             carry, cout_q;
  logic             cell_s, cell_co;
  logic [WIDTH-1:0] bit_mask;
`ifdef SERIAL_ADD_OVF_EN
  logic             ovf_q;
`endif

  // Shared full-adder cell
  always_comb begin
    cell_s   = a_sr[0] ^ b_sr[0] ^ carry;
    cell_co  = (a_sr[0] & b_sr[0]) | (a_sr[0] & carry) | (b_sr[0] & carry);
    bit_mask = WIDTH'(1) << cnt;
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = RUN;
      RUN:     if (cnt == LAST) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_sr   <= '0;
      b_sr   <= '0;
      sum_q  <= '0;
      cnt    <= '0;
      carry  <= 1'b0;
      cout_q <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
      ovf_q  <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: if (bus.start) begin
          a_sr  <= bus.a_in;
          b_sr  <= bus.b_in;
          carry <= bus.cin;
          cnt   <= '0;
        end
        RUN: begin
          // Only the addressed sum bit changes; unwritten bits keep their prior value
          sum_q <= (sum_q & ~bit_mask) | (cell_s ? bit_mask : '0);
          carry <= cell_co;
          a_sr  <= a_sr >> 1;
          b_sr  <= b_sr >> 1;
          if (cnt == LAST) begin
            cout_q <= cell_co;
`ifdef SERIAL_ADD_OVF_EN
            ovf_q  <= carry ^ cell_co;
`endif
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy = (state_q != IDLE);
  assign bus.done = (state_q == DONE);
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;
`ifdef SERIAL_ADD_OVF_EN
  assign bus.ovf  = ovf_q;
`endif
endmodule
